// File: rtl/booth_pp_accumulator.sv
// Sequential accumulator of radix-4 Booth partial-product rows producing a signed product.
// Optional BOOTH_ACC_BACK2BACK_EN lets row 0 of the next product enter during the output handshake.
module booth_pp_accumulator #(
    parameter int ROWS  = 8,
    parameter int PP_W  = 17,
    parameter int OUT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PP_W-1:0]           pp_row,
    input  logic                      pp_neg,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          product,
    output logic [$clog2(ROWS)-1:0]   row_cnt
);

    // state | meaning
    // ACC   | accepting rows, summing into acc
    // OUT   | holding product until downstream handshake
    typedef enum logic {ACC = 1'b0, OUT = 1'b1} state_t;

    localparam int CNT_W = $clog2(ROWS);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    state_t           state;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] row_ext;
    logic [OUT_W-1:0] weighted;
    logic             accept;

    // neg correction is summed at full width before the shift so 0x0FFFF+1 cannot wrap
    assign row_ext  = {{(OUT_W-PP_W){pp_row[PP_W-1]}}, pp_row} + OUT_W'(pp_neg);
    assign weighted = row_ext << {row_cnt, 1'b0};

`ifdef BOOTH_ACC_BACK2BACK_EN
    assign in_ready = (state == ACC) || out_ready || flush;
`else
    assign in_ready = (state == ACC) || flush;
`endif

    assign accept    = in_valid && in_ready;
    assign out_valid = (state == OUT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ACC;
            acc     <= '0;
            row_cnt <= '0;
            product <= '0;
        end else if (flush) begin
            state   <= ACC;
            acc     <= '0;
            row_cnt <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        if (row_cnt == LAST_ROW) begin
                            product <= acc + weighted;
                            acc     <= '0;
                            row_cnt <= '0;
                            state   <= OUT;
                        end else begin
                            acc     <= acc + weighted;
                            row_cnt <= row_cnt + CNT_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state <= ACC;
`ifdef BOOTH_ACC_BACK2BACK_EN
                        // row_cnt is 0 here, so weighted is row 0 of the next product
                        if (in_valid) begin
                            acc     <= weighted;
                            row_cnt <= CNT_W'(1);
                        end else begin
                            acc     <= '0;
                        end
`else
                        acc <= '0;
`endif
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Scoreboard bench for booth_pp_accumulator: directed Booth row vectors, monitor pops expected products.
module tb_booth_pp_accumulator;

    localparam int ROWS  = 8;
    localparam int PP_W  = 17;
    localparam int OUT_W = 32;

    typedef logic [PP_W:0] vec_t [ROWS];

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PP_W-1:0]   pp_row = '0;
    logic              pp_neg = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [OUT_W-1:0]  product;
    logic [2:0]        row_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs_last = -1;
    int hs_prev = -1;
    logic [OUT_W-1:0] exp_q[$];

    vec_t v35, vneg, vext;

    booth_pp_accumulator #(.ROWS(ROWS), .PP_W(PP_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pp_row(pp_row), .pp_neg(pp_neg),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .row_cnt(row_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endtask

    // Monitor: samples settled values between the driving negedge and the next active edge
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && !flush && out_valid && out_ready) begin
                hs_prev = hs_last;
                hs_last = cyc;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_product: got 0x%08h want none", product);
                end else begin
                    check("product", product, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_row(input logic [PP_W-1:0] p, input logic n);
        int b;
        bit ok;
        b  = 0;
        ok = 1'b0;
        pp_row   = p;
        pp_neg   = n;
        in_valid = 1'b1;
        while (!ok && b < 50) begin
            #1 ok = in_ready;
            @(negedge clk);
            b++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL row_accept_timeout: got in_ready=0 want 1");
        end
    endtask

    task automatic send_seq(input vec_t v, input logic [OUT_W-1:0] expv, input int nrows);
        if (nrows == ROWS) exp_q.push_back(expv);
        for (int i = 0; i < nrows; i++) send_row(v[i][PP_W-1:0], v[i][PP_W]);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < ROWS; i++) begin
            v35[i]  = '0;
            vneg[i] = {1'b1, 17'h1FFFF};
            vext[i] = '0;
        end
        v35[0]  = {1'b0, 17'h00003};
        v35[1]  = {1'b0, 17'h00003};
        vneg[0] = {1'b1, 17'h00000};
        vext[7] = {1'b1, 17'h0FFFF};

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product",   product,        32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_row_cnt",   32'(row_cnt),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 3 x 5, plus one-cycle latency after the last row
        send_seq(v35, 32'h0000000F, ROWS);
        #1 check("latency_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        drain();

        send_seq(vneg, 32'h00000001, ROWS);
        in_valid = 1'b0;
        drain();

        send_seq(vext, 32'h40000000, ROWS);
        in_valid = 1'b0;
        drain();

        // Backpressure: product held, no row accepted while waiting
        out_ready = 1'b0;
        send_seq(v35, 32'h0000000F, ROWS);
        pp_row   = 17'h00003;
        pp_neg   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_product",   product,        32'h0000000F);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_row_cnt",   32'(row_cnt),   32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready",  32'(in_ready),  32'd1);
        check("bp_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);

        // Back-to-back throughput, acc must be clean after the backpressure release
        send_seq(v35, 32'h0000000F, ROWS);
        send_seq(v35, 32'h0000000F, ROWS);
        in_valid = 1'b0;
        drain();
`ifdef BOOTH_ACC_BACK2BACK_EN
        check("throughput", 32'(hs_last - hs_prev), 32'(ROWS));
`else
        check("throughput", 32'(hs_last - hs_prev), 32'(ROWS + 1));
`endif

        // flush mid-operation drops the presented row
        send_seq(v35, 32'h0, 4);
        #1 check("mid_row_cnt", 32'(row_cnt), 32'd4);
        pp_row   = 17'h00003;
        pp_neg   = 1'b0;
        in_valid = 1'b1;
        flush    = 1'b1;
        #1 check("flush_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_row_cnt",   32'(row_cnt),   32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        send_seq(v35, 32'h0000000F, ROWS);
        in_valid = 1'b0;
        drain();

        // Reset mid-operation behaves like flush and clears product
        send_seq(v35, 32'h0, 4);
        pp_row   = 17'h00003;
        in_valid = 1'b1;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_mid_row_cnt", 32'(row_cnt),   32'd0);
        check("rst_mid_product", product,        32'd0);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        send_seq(v35, 32'h0000000F, ROWS);
        in_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
